// File: rtl/flit_input_buffer.sv
// Router input stage: buffers raw link flits in a small FIFO, resolves the
// output direction once per packet from the head flit, and presents flits
// downstream with a valid/ready handshake. One credit is returned upstream
// for every flit that leaves the FIFO, including dropped orphan flits.
//
// Ports:
//   CLK        clock, all state on posedge
//   RST_X      asynchronous active-low reset
//   IN         incoming flit, written when IN[W_FLIT-1] = 1
//   CREDIT_OUT one-cycle pulse, the cycle after each flit leaves the FIFO
//   OUT        front flit when presented, all zero otherwise
//   OUT_DIR    one-hot output direction of the current packet, 0 when idle
//   OUT_READY  downstream accepts OUT this cycle
//   ERR        one-cycle pulse on a protocol error (bad dest, orphan flit)
//   OVF        sticky overflow flag, set on a dropped write to a full FIFO
//   PKT_CNT    wrapping count of delivered tail flits
module flit_input_buffer #(
    parameter int W_FLIT = 8,
    parameter int W_DIR  = 5,
    parameter int DEPTH  = 4,
    parameter int W_CNT  = 8
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic [W_FLIT-1:0] IN,
    output logic              CREDIT_OUT,
    output logic [W_FLIT-1:0] OUT,
    output logic [W_DIR-1:0]  OUT_DIR,
    input  logic              OUT_READY,
    output logic              ERR,
    output logic              OVF,
    output logic [W_CNT-1:0]  PKT_CNT
);

    localparam int W_PTR = $clog2(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [W_FLIT-1:0] mem [DEPTH];
    logic [W_PTR-1:0]  wr_ptr;
    logic [W_PTR-1:0]  rd_ptr;
    logic [W_PTR:0]    count;
    logic [W_DIR-1:0]  dir_q;

    logic [W_FLIT-1:0] front;
    logic              nonempty;
    logic              full;
    logic              front_head;
    logic              front_tail;
    logic [2:0]        dest;
    logic              dest_bad;
    logic [W_DIR-1:0]  dec_dir;
    logic              present;
    logic              drop;
    logic              pop;
    logic              adv;
    logic              wr;

    assign front      = mem[rd_ptr];
    assign nonempty   = (count != '0);
    assign full       = (count == (W_PTR+1)'(DEPTH));
    assign front_head = front[W_FLIT-2];
    assign front_tail = front[W_FLIT-3];
    assign dest       = front[2:0];
    assign dest_bad   = (int'(dest) >= W_DIR);
    // Out-of-range destinations fall back to the local port (bit 0).
    assign dec_dir    = dest_bad ? W_DIR'(1) : (W_DIR'(1) << dest);

    // In IDLE only a head flit may be presented; any other front flit is an
    // orphan and is popped internally without ever appearing on OUT.
    assign present = nonempty && ((state == BUSY) || front_head);
    assign drop    = nonempty && (state == IDLE) && !front_head;
    assign pop     = present && OUT_READY;
    assign adv     = pop || drop;
    // A full FIFO still accepts a write when a slot frees up this same cycle.
    assign wr      = IN[W_FLIT-1] && (!full || adv);

    assign OUT     = present ? front : '0;
    assign OUT_DIR = present ? ((state == BUSY) ? dir_q : dec_dir) : '0;
    assign ERR     = drop || (pop && (state == IDLE) && dest_bad);

    always_ff @(posedge CLK) begin
        if (wr) begin
            mem[wr_ptr] <= IN;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dir_q      <= '0;
            CREDIT_OUT <= 1'b0;
            OVF        <= 1'b0;
            PKT_CNT    <= '0;
        end else begin
            CREDIT_OUT <= adv;
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (adv) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr, adv})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (IN[W_FLIT-1] && full && !adv) begin
                OVF <= 1'b1;
            end
            if (pop && front_tail) begin
                PKT_CNT <= PKT_CNT + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        dir_q <= dec_dir;
                        if (!front_tail) begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (pop && front_tail) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flit_input_buffer.sv
// Self-checking bench for flit_input_buffer: a vector table for the
// single-cycle-observable behaviour plus hand-written multi-cycle sequences
// (backpressure/overflow, full with simultaneous pop, async reset
// mid-packet). Popped flits are checked against a scoreboard queue filled
// when the flit is driven.
module tb_flit_input_buffer;

    logic       CLK;
    logic       RST_X;
    logic [7:0] IN;
    logic       CREDIT_OUT;
    logic [7:0] OUT;
    logic [4:0] OUT_DIR;
    logic       OUT_READY;
    logic       ERR;
    logic       OVF;
    logic [7:0] PKT_CNT;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];

    flit_input_buffer #(
        .W_FLIT(8),
        .W_DIR (5),
        .DEPTH (4),
        .W_CNT (8)
    ) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .IN        (IN),
        .CREDIT_OUT(CREDIT_OUT),
        .OUT       (OUT),
        .OUT_DIR   (OUT_DIR),
        .OUT_READY (OUT_READY),
        .ERR       (ERR),
        .OVF       (OVF),
        .PKT_CNT   (PKT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] din;
        logic       rdy;
        logic       push;
        logic [7:0] out;
        logic [4:0] dir;
        logic       err;
        logic       credit;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs (called just after a posedge), then move to the negedge
    // and compare any flit accepted this cycle against the scoreboard.
    task automatic apply(input logic [7:0] din, input logic rdy, input logic push);
        logic [7:0] exp;
        IN = din;
        OUT_READY = rdy;
        if (push) sb.push_back(din);
        @(negedge CLK);
        if (OUT[7] && OUT_READY) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pop", 32'(OUT), 32'h0);
            end else begin
                exp = sb.pop_front();
                chk("sb_flit", 32'(OUT), 32'(exp));
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_X = 1'b0;
        IN = '0;
        OUT_READY = 1'b0;
        sb.delete();
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RST_X = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            din    rdy   push  out    dir    err   cred  cnt
        vecs[0]  = '{8'hC2, 1'b1, 1'b1, 8'h00, 5'h00, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{8'h85, 1'b1, 1'b1, 8'hC2, 5'h04, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{8'hA7, 1'b1, 1'b1, 8'h85, 5'h04, 1'b0, 1'b1, 8'd0};
        vecs[3]  = '{8'h00, 1'b1, 1'b0, 8'hA7, 5'h04, 1'b0, 1'b1, 8'd0};
        vecs[4]  = '{8'h00, 1'b1, 1'b0, 8'h00, 5'h00, 1'b0, 1'b1, 8'd1};
        vecs[5]  = '{8'h00, 1'b1, 1'b0, 8'h00, 5'h00, 1'b0, 1'b0, 8'd1};
        vecs[6]  = '{8'hC6, 1'b1, 1'b1, 8'h00, 5'h00, 1'b0, 1'b0, 8'd1};
        vecs[7]  = '{8'hA1, 1'b1, 1'b1, 8'hC6, 5'h01, 1'b1, 1'b0, 8'd1};
        vecs[8]  = '{8'h00, 1'b1, 1'b0, 8'hA1, 5'h01, 1'b0, 1'b1, 8'd1};
        vecs[9]  = '{8'h00, 1'b1, 1'b0, 8'h00, 5'h00, 1'b0, 1'b1, 8'd2};
        vecs[10] = '{8'h81, 1'b1, 1'b0, 8'h00, 5'h00, 1'b0, 1'b0, 8'd2};
        vecs[11] = '{8'h00, 1'b1, 1'b0, 8'h00, 5'h00, 1'b1, 1'b0, 8'd2};
        vecs[12] = '{8'h00, 1'b1, 1'b0, 8'h00, 5'h00, 1'b0, 1'b1, 8'd2};
        vecs[13] = '{8'hE3, 1'b1, 1'b1, 8'h00, 5'h00, 1'b0, 1'b0, 8'd2};
        vecs[14] = '{8'h00, 1'b1, 1'b0, 8'hE3, 5'h08, 1'b0, 1'b0, 8'd2};
        vecs[15] = '{8'h00, 1'b1, 1'b0, 8'h00, 5'h00, 1'b0, 1'b1, 8'd3};

        RST_X = 1'b0;
        IN = '0;
        OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_out", 32'(OUT), 32'h0);
        chk("rst_dir", 32'(OUT_DIR), 32'h0);
        chk("rst_credit", 32'(CREDIT_OUT), 32'h0);
        chk("rst_err", 32'(ERR), 32'h0);
        chk("rst_ovf", 32'(OVF), 32'h0);
        chk("rst_cnt", 32'(PKT_CNT), 32'h0);
        @(posedge CLK);
        #1;
        RST_X = 1'b1;

        // Packet, bad destination, orphan body and single-flit packet.
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].din, vecs[i].rdy, vecs[i].push);
            chk($sformatf("v%0d_out", i), 32'(OUT), 32'(vecs[i].out));
            chk($sformatf("v%0d_dir", i), 32'(OUT_DIR), 32'(vecs[i].dir));
            chk($sformatf("v%0d_err", i), 32'(ERR), 32'(vecs[i].err));
            chk($sformatf("v%0d_credit", i), 32'(CREDIT_OUT), 32'(vecs[i].credit));
            chk($sformatf("v%0d_cnt", i), 32'(PKT_CNT), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_ovf", i), 32'(OVF), 32'h0);
            tick();
        end
        chk("tbl_sb_empty", 32'(sb.size()), 32'h0);

        // Backpressure: five writes into four entries, fifth dropped.
        do_reset();
        apply(8'hC1, 1'b0, 1'b1); tick();
        apply(8'h82, 1'b0, 1'b1); tick();
        apply(8'h83, 1'b0, 1'b1); tick();
        apply(8'h84, 1'b0, 1'b1);
        chk("bp_ovf_pre", 32'(OVF), 32'h0);
        tick();
        apply(8'hA5, 1'b0, 1'b0);
        chk("bp_ovf_full", 32'(OVF), 32'h0);
        tick();
        apply(8'h00, 1'b0, 1'b0);
        chk("bp_ovf_set", 32'(OVF), 32'h1);
        chk("bp_hold_out", 32'(OUT), 32'hC1);
        chk("bp_hold_dir", 32'(OUT_DIR), 32'h02);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(8'h00, 1'b1, 1'b0);
            tick();
        end
        apply(8'h00, 1'b1, 1'b0);
        chk("bp_no_fifth", 32'(OUT), 32'h0);
        chk("bp_sb_empty", 32'(sb.size()), 32'h0);
        chk("bp_ovf_sticky", 32'(OVF), 32'h1);
        tick();

        // Full FIFO with a write and a pop in the same cycle.
        do_reset();
        apply(8'hC1, 1'b0, 1'b1); tick();
        apply(8'h82, 1'b0, 1'b1); tick();
        apply(8'h83, 1'b0, 1'b1); tick();
        apply(8'h84, 1'b0, 1'b1); tick();
        apply(8'hA5, 1'b1, 1'b1); tick();
        apply(8'h00, 1'b0, 1'b0);
        chk("fp_ovf", 32'(OVF), 32'h0);
        chk("fp_next_out", 32'(OUT), 32'h82);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(8'h00, 1'b1, 1'b0);
            tick();
        end
        apply(8'h00, 1'b1, 1'b0);
        chk("fp_empty_out", 32'(OUT), 32'h0);
        chk("fp_sb_empty", 32'(sb.size()), 32'h0);
        chk("fp_cnt", 32'(PKT_CNT), 32'h1);
        chk("fp_ovf_end", 32'(OVF), 32'h0);
        tick();

        // Async reset after a head pop, with a body flit still buffered.
        do_reset();
        apply(8'hE1, 1'b1, 1'b1); tick();
        apply(8'hC2, 1'b1, 1'b1); tick();
        apply(8'h83, 1'b1, 1'b0); tick();
        apply(8'h00, 1'b0, 1'b0);
        chk("ar_pre_out", 32'(OUT), 32'h83);
        chk("ar_pre_cnt", 32'(PKT_CNT), 32'h1);
        chk("ar_pre_dir", 32'(OUT_DIR), 32'h04);
        #2;
        RST_X = 1'b0;
        #1;
        chk("ar_out", 32'(OUT), 32'h0);
        chk("ar_dir", 32'(OUT_DIR), 32'h0);
        chk("ar_cnt", 32'(PKT_CNT), 32'h0);
        chk("ar_credit", 32'(CREDIT_OUT), 32'h0);
        chk("ar_err", 32'(ERR), 32'h0);
        @(posedge CLK);
        #1;
        RST_X = 1'b1;
        sb.delete();
        apply(8'h00, 1'b1, 1'b0);
        chk("ar_no_credit", 32'(CREDIT_OUT), 32'h0);
        chk("ar_idle_out", 32'(OUT), 32'h0);
        tick();
        apply(8'hE4, 1'b1, 1'b1); tick();
        apply(8'h00, 1'b1, 1'b0);
        chk("ar_fresh_out", 32'(OUT), 32'hE4);
        chk("ar_fresh_dir", 32'(OUT_DIR), 32'h10);
        tick();
        apply(8'h00, 1'b1, 1'b0);
        chk("ar_fresh_credit", 32'(CREDIT_OUT), 32'h1);
        chk("ar_fresh_cnt", 32'(PKT_CNT), 32'h1);
        chk("ar_sb_empty", 32'(sb.size()), 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
